// File: rtl/arcadia_8b10b_pkg.sv
// Shared 8b10b types and constants used by the packet encoder and its line-side peers.
// Symbols are carried as {k, byte}; line words pack two 10-bit symbols, lower one first.
package arcadia_8b10b_pkg;

    localparam logic [7:0] K28_5     = 8'hBC;
    localparam logic [9:0] K28_5_RDN = 10'h17C;
    localparam logic [9:0] K28_5_RDP = 10'h283;

    typedef struct packed {
        logic       k;
        logic [7:0] data;
    } sym9_t;

    typedef logic [19:0] line_word_t;
    typedef logic [31:0] packet_t;

    localparam sym9_t K28_5_SYM = '{k: 1'b1, data: K28_5};

    // Which half of a packet the next data slot carries.
    typedef enum logic {
        PH_LSB = 1'b0,
        PH_MSB = 1'b1
    } phase_e;

    function automatic sym9_t data_sym(input logic [7:0] b);
        return '{k: 1'b0, data: b};
    endfunction

endpackage

// File: rtl/packet_encoder_8b10b_if.sv
// Packet-side valid/ready handshake into the 8b10b packet encoder.
// The master drives 32-bit packets; the encoder (slave) answers with In_Ready.
interface packet_encoder_8b10b_if;
    import arcadia_8b10b_pkg::*;

    packet_t In_Data;
    logic    In_Valid;
    logic    In_Ready;

    modport master (
        output In_Data,
        output In_Valid,
        input  In_Ready
    );

    modport slave (
        input  In_Data,
        input  In_Valid,
        output In_Ready
    );

endinterface

// File: rtl/packet_encoder_8b10b_enc.sv
// Combinational 8b10b symbol encoder, mirror of decode8b10b.
// datain = {k, HGFEDCBA}; dataout bit0 = a ... bit9 = j; dispin/dispout 0 = negative.
module encode8b10b (
    input  logic [8:0] datain,
    input  logic       dispin,
    output logic [9:0] dataout,
    output logic       dispout
);

    logic ai, bi, ci, di, ei, fi, gi, hi, ki;
    logic aeqb, ceqd, l22, l40, l04, l13, l31;
    logic sa, sb, sc, sd, se, si, sf, sg, sh, sj;
    logic pd1s6, nd1s6, ndos6, pdos6;
    logic nd1s4, pd1s4, ndos4, pdos4;
    logic alt7, compls6, compls4, disp6;

    assign {ki, hi, gi, fi, ei, di, ci, bi, ai} = datain;

    assign aeqb = (ai & bi) | (!ai & !bi);
    assign ceqd = (ci & di) | (!ci & !di);
    assign l22  = (ai & bi & !ci & !di) | (ci & di & !ai & !bi) | (!aeqb & !ceqd);
    assign l40  = ai & bi & ci & di;
    assign l04  = !ai & !bi & !ci & !di;
    assign l13  = (!aeqb & !ci & !di) | (!ceqd & !ai & !bi);
    assign l31  = (!aeqb & ci & di) | (!ceqd & ai & bi);

    // 5b/6b sub-block, written for negative incoming disparity before complementing
    assign sa = ai;
    assign sb = (bi & !l40) | l04;
    assign sc = l04 | ci | (ei & di & !ci & !bi & !ai);
    assign sd = di & !(ai & bi & ci);
    assign se = (ei | l13) & !(ei & di & !ci & !bi & !ai);
    assign si = (l22 & !ei)
              | (ei & !di & !ci & !(ai & bi))
              | (ei & l40)
              | (ki & ei & di & ci & !bi & !ai)
              | (ei & !di & ci & !bi & !ai);

    assign pd1s6 = (ei & di & !ci & !bi & !ai) | (!ei & !l22 & !l31);
    assign nd1s6 = ki | (ei & !l22 & !l13) | (!ei & !di & ci & bi & ai);
    assign ndos6 = pd1s6;
    assign pdos6 = ki | (ei & !l22 & !l13);

    // Dx.A7 replaces Dx.P7 where the plain code would create a run of five
    assign alt7 = fi & gi & hi & (ki | (dispin ? (!ei & di & l31) : (ei & !di & l13)));

    assign sf = fi & !alt7;
    assign sg = gi | (!fi & !gi & !hi);
    assign sh = hi;
    assign sj = (!hi & (gi ^ fi)) | alt7;

    assign nd1s4 = fi & gi;
    assign pd1s4 = (!fi & !gi) | (ki & ((fi & !gi) | (!fi & gi)));
    assign ndos4 = !fi & !gi;
    assign pdos4 = fi & gi & hi;

    assign compls6 = (pd1s6 & !dispin) | (nd1s6 & dispin);
    assign disp6   = dispin ^ (ndos6 | pdos6);
    assign compls4 = (pd1s4 & !disp6) | (nd1s4 & disp6);
    assign dispout = disp6 ^ (ndos4 | pdos4);

    assign dataout = {sj ^ compls4, sh ^ compls4, sg ^ compls4, sf ^ compls4,
                      si ^ compls6, se ^ compls6, sd ^ compls6, sc ^ compls6,
                      sb ^ compls6, sa ^ compls6};

endmodule

// File: rtl/packet_encoder_8b10b.sv
// 32-bit packet to 8b10b line encoder: two 16-bit halves per packet, LSB half first,
// with K28.5 comma words for init, periodic/forced sync and idle slots.
module packet_encoder_8b10b
    import arcadia_8b10b_pkg::*;
#(
    parameter int unsigned INIT_COMMAS   = 4,
    parameter int unsigned SYNC_INTERVAL = 16,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    packet_encoder_8b10b_if.slave   in_if,
    input  logic                    Force_Sync,
    output line_word_t              O,
    output logic                    Comma
);

    localparam logic [CNT_W-1:0] INIT_LOAD = CNT_W'(INIT_COMMAS);
    localparam logic [CNT_W-1:0] SYNC_LIM  = CNT_W'(SYNC_INTERVAL);
    localparam bit               SYNC_EN   = (SYNC_INTERVAL != 0);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] sync_cnt_q, sync_cnt_d;
    logic             sync_req_q, sync_req_d;
    logic [15:0]      msb_q, msb_d;
    logic             rd_q, rd_d;
    line_word_t       o_q, o_d;
    logic             comma_q, comma_d;

    sym9_t            lo_sym, hi_sym;
    logic [9:0]       lo_code, hi_code;
    logic             lo_disp, hi_disp;
    logic             sync_due, comma_due;

    assign sync_due  = SYNC_EN && (sync_cnt_q == SYNC_LIM);
    assign comma_due = (init_cnt_q != '0) || sync_req_q || sync_due;

    // Ready depends on registered state only, so it never combines with In_Valid.
    assign in_if.In_Ready = (phase_q == PH_LSB) && !comma_due;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        phase_d    = phase_q;
        init_cnt_d = init_cnt_q;
        sync_cnt_d = sync_cnt_q;
        sync_req_d = sync_req_q | Force_Sync;
        msb_d      = msb_q;
        lo_sym     = K28_5_SYM;
        hi_sym     = K28_5_SYM;
        comma_d    = 1'b1;

        if (phase_q == PH_MSB) begin
            // Second half always directly follows the first; sync requests wait.
            lo_sym  = data_sym(msb_q[7:0]);
            hi_sym  = data_sym(msb_q[15:8]);
            comma_d = 1'b0;
            phase_d = PH_LSB;
        end else if (comma_due) begin
            if (init_cnt_q != '0) begin
                init_cnt_d = init_cnt_q - CNT_W'(1);
            end
            sync_req_d = Force_Sync;
            sync_cnt_d = '0;
        end else if (in_if.In_Valid) begin
            lo_sym  = data_sym(in_if.In_Data[7:0]);
            hi_sym  = data_sym(in_if.In_Data[15:8]);
            msb_d   = in_if.In_Data[31:16];
            comma_d = 1'b0;
            phase_d = PH_MSB;
            if (sync_cnt_q != '1) begin
                sync_cnt_d = sync_cnt_q + CNT_W'(1);
            end
        end else begin
            sync_cnt_d = '0;
        end
    end

    encode8b10b u_enc_lo (
        .datain  (lo_sym),
        .dispin  (rd_q),
        .dataout (lo_code),
        .dispout (lo_disp)
    );

    encode8b10b u_enc_hi (
        .datain  (hi_sym),
        .dispin  (lo_disp),
        .dataout (hi_code),
        .dispout (hi_disp)
    );

    assign o_d  = {hi_code, lo_code};
    assign rd_d = hi_disp;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q    <= PH_LSB;
            init_cnt_q <= INIT_LOAD;
            sync_cnt_q <= '0;
            sync_req_q <= 1'b0;
            msb_q      <= '0;
            rd_q       <= 1'b0;
            o_q        <= '0;
            comma_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            phase_q    <= phase_d;
            init_cnt_q <= init_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            sync_req_q <= sync_req_d;
            msb_q      <= msb_d;
            rd_q       <= rd_d;
            o_q        <= o_d;
            comma_q    <= comma_d;
        end
    end

    assign O     = o_q;
    assign Comma = comma_q;

endmodule

// File: doc/packet_encoder_8b10b.md
Name: packet_encoder_8b10b

Overview:
Transmit-side counterpart of the periphery 8b10b packet decoder. It accepts 32-bit packets over a valid/ready handshake and splits each into two 16-bit halves, LSB half first. Each half is 8b10b-encoded as two symbols per clock with chained running disparity, giving a registered 20-bit line word. Idle and sync slots carry K28.5 comma words so the receiver can realign its half-word pairing.

Parameters:
INIT_COMMAS, 4, number of forced comma words emitted after reset before the first packet is accepted (≥1)
SYNC_INTERVAL, 16, maximum packets sent back-to-back before a comma is forced; 0 disables forced sync
CNT_W, 8, width of the init/sync counters (must hold max(INIT_COMMAS, SYNC_INTERVAL))

Ports:
Clock  input  1  single clock; all state updates on its rising edge
Reset_n  input  1  asynchronous, active-low reset
In_Data  input  32  packet; [15:0] is sent first, [31:16] second
In_Valid  input  1  In_Data is valid
In_Ready  output  1  encoder accepts In_Data this cycle
Force_Sync  input  1  request one comma word at the next non-MSB slot
O  output  20  registered line word; O[9:0] is the earlier (lower) symbol, O[19:10] the later (upper) symbol
Comma  output  1  registered; 1 when O currently carries a comma word

Behaviour:
- Reset (async, Reset_n=0):
  - O=20'd0, Comma=0, running disparity RD=0 (negative), pending_msb=0.
  - init_cnt=INIT_COMMAS, sync_cnt=0, sync_req=0.
- Slot priority, evaluated every cycle, highest first:
  1. pending_msb: emit In_Data[31:16] held from the accept cycle; clear pending_msb.
  2. init_cnt>0, sync_req, or (SYNC_INTERVAL>0 and sync_cnt==SYNC_INTERVAL): emit comma; decrement init_cnt if >0; clear sync_req; sync_cnt=0.
  3. In_Valid: emit {K=0,In_Data[15:8]} upper / {K=0,In_Data[7:0]} lower; hold In_Data[31:16]; set pending_msb; sync_cnt++ (saturating).
  4. Otherwise: emit comma; sync_cnt=0.
- In_Ready is combinational from registers only: !pending_msb && init_cnt==0 && !sync_req && !(SYNC_INTERVAL>0 && sync_cnt==SYNC_INTERVAL). It does not depend on In_Valid.
- Force_Sync:
  - Sets sync_req; the request is sticky until the comma is emitted.
  - When it arrives during pending_msb, the MSB is emitted first and the comma follows.
- Comma word:
  - Lower symbol K28.5 (K=1, 0xBC), upper symbol K28.5.
  - Only the lower symbol must be K28.5 for receiver realignment; the upper one is fixed as K28.5 here.
- Disparity chaining:
  - The lower symbol is encoded with RD; the upper symbol with the lower symbol's dispout.
  - RD<=upper dispout each cycle.
- Latency: a packet accepted at edge t appears as its LSB word on O after edge t, and its MSB word after edge t+1.
- Throughput: one packet per 2 cycles maximum. Halves of one packet are never separated by a comma.
- Data byte 0xBC with K=0 is ordinary data and is encoded as D28.5.
- Symbol bit order matches decode8b10b datain: bit0=a … bit9=j.
  - K28.5 RD- = 10'h17C; K28.5 RD+ = 10'h283.
- Reset mid-packet (after LSB, before MSB): the MSB half is dropped, pending_msb cleared, and the init comma sequence restarts.

Decomposition:
- Shared package arcadia_8b10b_pkg:
  - K28_5 byte constant (8'hBC).
  - Comma symbol constants (RD-/RD+).
  - Typedef for a 9-bit {k, byte} symbol and a 20-bit line word.
  - Typedef for a 32-bit packet.
- One sub-module, encode8b10b: purely combinational; datain[8:0]={k,byte}, dispin, dataout[9:0], dispout. It is the mirror of decode8b10b and is instantiated twice (lower, upper).
- Slot-select control and disparity register stay in packet_encoder_8b10b.

Test Plan:
1. Reset release, In_Valid=1 → 4 comma words O=20'h283_17C-pattern ({10'h283,10'h17C} with RD=0 at start); In_Ready=0 for 4 cycles, 1 on the 5th; Comma=1 for those 4 words.
2. Single packet 32'hDEADBEEF after init → LSB word then MSB word; looped into the decoder, it yields O=32'hDEADBEEF with Ready pulsing once and zero code_err/disp_err.
3. SYNC_INTERVAL=4, In_Valid held high → exactly 4 packets (8 words), then 1 comma with In_Ready=0 that cycle, repeating; all packets recovered by the decoder in order.
4. Packet 32'h00BC00BC → lower symbols encoded as D28.5, Comma=0, and the decoder does not realign mid-packet.
5. Force_Sync pulsed in the cycle after an accept → MSB word emitted first, then one comma, then the next packet is accepted.
6. Reset_n asserted between LSB and MSB, plus 1000 random back-to-back packets → MSB dropped, O=0 during reset, re-init commas; random run shows bounded disparity (±1), run length ≤5, and zero decoder errors.
